load_store_unit: RTL

Memory-stage responder for the ALU memory-op output. Accepts one load or store per transaction, checks alignment and funct3, runs a request/acknowledge access on the data-memory port, and returns load results as a register writeback. Sits between the ALU memory-op output and the data memory; its writeback feeds the register-file write arbiter.

---
 rtl/load_store_unit.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// Memory-stage load/store responder: validates funct3/alignment, runs a req/ack data-memory access
// with timeout abort, and returns formatted load data as a one-cycle register writeback pulse.
module load_store_unit #(
  parameter int XLEN    = 32,
  parameter int REG_W   = 5,
  parameter int TIMEOUT = 255
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic [XLEN-1:0]  iAddr,
  input  logic [XLEN-1:0]  iData,
  input  logic [REG_W-1:0] iRdAddr,
  input  logic [2:0]       iOpType,
  input  logic             iRead,
  input  logic             iWrite,
  output logic             oReady,
  output logic             oMemReq,
  output logic             oMemWe,
  output logic [XLEN-1:0]  oMemAddr,
  output logic [XLEN-1:0]  oMemWdata,
  output logic [3:0]       oMemBe,
  input  logic [XLEN-1:0]  iMemRdata,
  input  logic             iMemAck,
  output logic             oRegDv,
  output logic [REG_W-1:0] oRegAddr,
  output logic [XLEN-1:0]  oRegData,
  output logic             oErr
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_t           r_state, w_state_nxt;
  logic [15:0]      r_cnt, w_cnt_nxt;
  logic             r_mem_req, w_req_nxt;
  logic             r_mem_we, w_we_nxt;
  logic [XLEN-1:0]  r_mem_addr, w_addr_nxt;
  logic [XLEN-1:0]  r_mem_wdata, w_wdata_nxt;
  logic [3:0]       r_mem_be, w_be_nxt;
  logic [2:0]       r_op, w_op_nxt;
  logic [REG_W-1:0] r_rd, w_rd_nxt;
  logic [1:0]       r_lane, w_lane_nxt;
  logic             r_reg_dv, w_dv_nxt;
  logic [REG_W-1:0] r_reg_addr, w_reg_addr_nxt;
  logic [XLEN-1:0]  r_reg_data, w_reg_data_nxt;
  logic             r_err, w_err_nxt;

  logic             w_legal, w_misalign;
  logic [XLEN-1:0]  w_st_wdata;
  logic [3:0]       w_st_be;
  logic [7:0]       w_ld_byte;
  logic [15:0]      w_ld_half;
  logic [XLEN-1:0]  w_ld_fmt;

  // Request decode: legality, alignment and lane-replicated store formatting.
  always_comb begin
    w_legal    = iWrite ? (iOpType inside {3'd0, 3'd1, 3'd2})
                        : (iOpType inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    w_misalign = ((iOpType[1:0] == 2'd1) && iAddr[0]) ||
                 ((iOpType[1:0] == 2'd2) && (iAddr[1:0] != 2'b00));
    w_st_wdata = iData;
    w_st_be    = 4'b1111;
    case (iOpType[1:0])
      2'd0: begin
        w_st_wdata = {4{iData[7:0]}};
        w_st_be    = 4'b0001 << iAddr[1:0];
      end
      2'd1: begin
        w_st_wdata = {2{iData[15:0]}};
        w_st_be    = 4'b0011 << iAddr[1:0];
      end
      default: ;
    endcase
    if (!iWrite) w_st_be = 4'b1111;
  end

  // Load formatting from the lane captured at accept time.
  always_comb begin
    w_ld_byte = iMemRdata[{r_lane, 3'b000} +: 8];
    w_ld_half = iMemRdata[{r_lane[1], 4'b0000} +: 16];
    case (r_op)
      3'd0:    w_ld_fmt = {{(XLEN-8){w_ld_byte[7]}}, w_ld_byte};
      3'd1:    w_ld_fmt = {{(XLEN-16){w_ld_half[15]}}, w_ld_half};
      3'd4:    w_ld_fmt = {{(XLEN-8){1'b0}}, w_ld_byte};
      3'd5:    w_ld_fmt = {{(XLEN-16){1'b0}}, w_ld_half};
      default: w_ld_fmt = iMemRdata;
    endcase
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_req_nxt      = r_mem_req;
    w_we_nxt       = r_mem_we;
    w_addr_nxt     = r_mem_addr;
    w_wdata_nxt    = r_mem_wdata;
    w_be_nxt       = r_mem_be;
    w_op_nxt       = r_op;
    w_rd_nxt       = r_rd;
    w_lane_nxt     = r_lane;
    w_dv_nxt       = 1'b0;
    w_reg_addr_nxt = r_reg_addr;
    w_reg_data_nxt = r_reg_data;
    w_err_nxt      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (iRead || iWrite) begin
          if ((iRead && iWrite) || !w_legal || w_misalign) begin
            w_err_nxt = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = '0;
            w_req_nxt   = 1'b1;
            w_we_nxt    = iWrite;
            w_addr_nxt  = {iAddr[XLEN-1:2], 2'b00};
            w_wdata_nxt = w_st_wdata;
            w_be_nxt    = w_st_be;
            w_op_nxt    = iOpType;
            w_rd_nxt    = iRdAddr;
            w_lane_nxt  = iAddr[1:0];
          end
        end
      end
      S_WAIT: begin
        // An ack arriving on the timeout cycle still completes the access.
        if (iMemAck) begin
          w_state_nxt = S_IDLE;
          w_req_nxt   = 1'b0;
          if (!r_mem_we && (r_rd != '0)) begin
            w_dv_nxt       = 1'b1;
            w_reg_addr_nxt = r_rd;
            w_reg_data_nxt = w_ld_fmt;
          end
        end else if (r_cnt == TO_LAST) begin
          w_state_nxt = S_IDLE;
          w_req_nxt   = 1'b0;
          w_err_nxt   = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 16'd1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge iClk or negedge iRst) begin
    if (!iRst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_be    <= '0;
      r_op        <= '0;
      r_rd        <= '0;
      r_lane      <= '0;
      r_reg_dv    <= 1'b0;
      r_reg_addr  <= '0;
      r_reg_data  <= '0;
      r_err       <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mem_req   <= w_req_nxt;
      r_mem_we    <= w_we_nxt;
      r_mem_addr  <= w_addr_nxt;
      r_mem_wdata <= w_wdata_nxt;
      r_mem_be    <= w_be_nxt;
      r_op        <= w_op_nxt;
      r_rd        <= w_rd_nxt;
      r_lane      <= w_lane_nxt;
      r_reg_dv    <= w_dv_nxt;
      r_reg_addr  <= w_reg_addr_nxt;
      r_reg_data  <= w_reg_data_nxt;
      r_err       <= w_err_nxt;
    end
  end

  assign oReady    = (r_state == S_IDLE);
  assign oMemReq   = r_mem_req;
  assign oMemWe    = r_mem_we;
  assign oMemAddr  = r_mem_addr;
  assign oMemWdata = r_mem_wdata;
  assign oMemBe    = r_mem_be;
  assign oRegDv    = r_reg_dv;
  assign oRegAddr  = r_reg_addr;
  assign oRegData  = r_reg_data;
  assign oErr      = r_err;

endmodule
